// File: rtl/wave_gen.sv
// Square-wave generator: r high for m units, low for n units, one unit = TICKS_PER_UNIT clocks.
// Optional WAVEGEN_PERIOD_PULSE_EN adds a one-cycle period_start pulse on every ON entry.
module wave_gen #(
    parameter int TICKS_PER_UNIT = 5,
    parameter int W              = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] m,
    input  logic [W-1:0] n,
    output logic         r
`ifdef WAVEGEN_PERIOD_PULSE_EN
    ,
    output logic         period_start
`endif
);

    localparam int TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_UNIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [W-1:0]  unit_q, unit_d;
    logic [W-1:0]  len_q, len_d;
    logic          r_q, r_d;
    logic          last_tick;
    logic          phase_end;
    logic          enter;
    logic          pref_on;
    logic [W-1:0]  pref_len;
    logic [W-1:0]  alt_len;

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        unit_d    = unit_q;
        len_d     = len_q;
        last_tick = (tick_q == TICK_MAX);
        phase_end = (state_q != IDLE) && last_tick && (unit_q == len_q - W'(1));
        enter     = (state_q == IDLE) || phase_end;
        // Preferred phase alternates; a zero-length phase is skipped.
        pref_on   = (state_q != ON);
        pref_len  = pref_on ? m : n;
        alt_len   = pref_on ? n : m;

        if (enter) begin
            tick_d = '0;
            unit_d = '0;
            if (pref_len != '0) begin
                state_d = pref_on ? ON : OFF;
                len_d   = pref_len;
            end else if (alt_len != '0) begin
                state_d = pref_on ? OFF : ON;
                len_d   = alt_len;
            end else begin
                state_d = IDLE;
                len_d   = '0;
            end
        end else if (last_tick) begin
            tick_d = '0;
            unit_d = unit_q + W'(1);
        end else begin
            tick_d = tick_q + TW'(1);
        end

        r_d = (state_d == ON);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            unit_q  <= '0;
            len_q   <= '0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            unit_q  <= unit_d;
            len_q   <= len_d;
            r_q     <= r_d;
        end
    end

    assign r = r_q;

`ifdef WAVEGEN_PERIOD_PULSE_EN
    logic ps_q, ps_d;

    always_comb begin
        ps_d = enter && (state_d == ON);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q <= 1'b0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign period_start = ps_q;
`endif

endmodule

// File: tb/tb_wave_gen.sv
// Scoreboard bench for wave_gen: directed segment tables push expected r per cycle,
// a negedge monitor pops and compares.
module tb_wave_gen;

    localparam int K = 5;

    logic       clk;
    logic       reset;
    logic [3:0] m;
    logic [3:0] n;
    logic       r;
`ifdef WAVEGEN_PERIOD_PULSE_EN
    logic       period_start;
`endif

    typedef struct {
        logic er;
        logic eps;
        int   id;
    } exp_t;

    exp_t exp_q[$];
    int   vectors   = 0;
    int   miscompares = 0;
    int   seq       = 0;

    wave_gen #(.TICKS_PER_UNIT(K), .W(4)) dut (
        .clk(clk),
        .reset(reset),
        .m(m),
        .n(n),
        .r(r)
`ifdef WAVEGEN_PERIOD_PULSE_EN
        ,
        .period_start(period_start)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one output sample per cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (r !== e.er) begin
                miscompares++;
                $display("FAIL r vec %0d: got %b expected %b", e.id, r, e.er);
            end
`ifdef WAVEGEN_PERIOD_PULSE_EN
            vectors++;
            if (period_start !== e.eps) begin
                miscompares++;
                $display("FAIL period_start vec %0d: got %b expected %b",
                         e.id, period_start, e.eps);
            end
`endif
        end
    end

    task automatic cyc(input logic rst, input logic [3:0] mv, input logic [3:0] nv,
                       input logic er, input logic eps);
        exp_t e;
        reset = rst;
        m     = mv;
        n     = nv;
        e.er  = er;
        e.eps = eps;
        e.id  = seq;
        seq++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cyc(input logic [3:0] mv, input logic [3:0] nv);
        cyc(1'b1, mv, nv, 1'b0, 1'b0);
    endtask

    // A run of len cycles at level lv; ps marks an ON entry on the first cycle.
    task automatic seg(input logic lv, input int len, input logic [3:0] mv,
                       input logic [3:0] nv, input logic ps);
        for (int i = 0; i < len; i++) begin
            cyc(1'b0, mv, nv, lv, ps && (i == 0));
        end
    endtask

    initial begin
        reset = 1'b1;
        m     = '0;
        n     = '0;

        // Basic waveform m=9 n=4: 45 high, 20 low
        rst_cyc(4'd9, 4'd4);
        for (int p = 0; p < 4; p++) begin
            seg(1'b1, 45, 4'd9, 4'd4, 1'b1);
            seg(1'b0, 20, 4'd9, 4'd4, 1'b0);
        end
        seg(1'b1, 40, 4'd9, 4'd4, 1'b1);

        // Zero on-time
        rst_cyc(4'd0, 4'd4);
        seg(1'b0, 60, 4'd0, 4'd4, 1'b0);

        // Zero off-time: r stays high, ON re-entered every 20 cycles
        rst_cyc(4'd4, 4'd0);
        for (int p = 0; p < 5; p++) begin
            seg(1'b1, 20, 4'd4, 4'd0, 1'b1);
        end

        // Both zero
        rst_cyc(4'd0, 4'd0);
        seg(1'b0, 30, 4'd0, 4'd0, 1'b0);

        // Maximum setting
        rst_cyc(4'd15, 4'd15);
        for (int p = 0; p < 2; p++) begin
            seg(1'b1, 75, 4'd15, 4'd15, 1'b1);
            seg(1'b0, 75, 4'd15, 4'd15, 1'b0);
        end

        // Reset mid-phase at cycle 20 of ON
        rst_cyc(4'd9, 4'd4);
        seg(1'b1, 20, 4'd9, 4'd4, 1'b1);
        rst_cyc(4'd9, 4'd4);
        seg(1'b1, 45, 4'd9, 4'd4, 1'b1);
        seg(1'b0, 20, 4'd9, 4'd4, 1'b0);
        seg(1'b1, 5, 4'd9, 4'd4, 1'b1);

        // Setting change mid-ON: m 9 -> 2 only takes effect at next ON entry
        rst_cyc(4'd9, 4'd4);
        seg(1'b1, 10, 4'd9, 4'd4, 1'b1);
        seg(1'b1, 35, 4'd2, 4'd4, 1'b0);
        seg(1'b0, 20, 4'd2, 4'd4, 1'b0);
        seg(1'b1, 10, 4'd2, 4'd4, 1'b1);
        seg(1'b0, 20, 4'd2, 4'd4, 1'b0);
        seg(1'b1, 10, 4'd2, 4'd4, 1'b1);

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
